// File: rtl/mem_access_unit_if.sv
// Purpose : bundles the core request/response handshake and the word-RAM port of mem_access_unit.
// Latency : none, wiring only.
// Backpressure: the unit drives req_ready; the core holds its request until it is accepted.
// Ports (by modport):
//   slave  - the access unit: takes req_* and mem_rdata, drives req_ready, resp_* and mem_* controls
//   master - the core/RAM side: drives req_* and mem_rdata, observes everything else
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_write;
    logic                  mem_read;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_write, mem_read
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/mem_access_unit.sv
// Purpose : turns MIPS byte/half/word loads and stores into word accesses on a sync RAM,
//           extracting/extending loads, doing read-modify-write for sub-word stores, and
//           flagging misaligned or illegal-size requests.
// Latency : accept-to-resp_valid is 2 cycles for loads and SB/SH, 1 cycle for SW and errors.
// Backpressure: req_ready is high only in IDLE; the core stalls until the request is taken.
// Ports   : clk, rst (async, active high); bus = mem_access_unit_if.slave (core request/response
//           and RAM address/data/enables).
// Config  : define MEM_BIG_ENDIAN_EN for MIPS big-endian lane numbering (default little-endian).
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_unit_if.slave   bus
);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {IDLE, RD, LDR, RMW, WR, ERR} state_t;

    state_t                state;
    logic                  lat_write;
    logic [1:0]            lat_size;
    logic                  lat_signed;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic                  req_ready_q;
    logic                  resp_valid_q;
    logic                  resp_err_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;

    logic                  misaligned;
    logic [1:0]            byte_lane;
    logic                  half_lane;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [DATA_WIDTH-1:0] ld_val;
    logic [DATA_WIDTH-1:0] merged;

    // Alignment is judged on the live request so the error path never touches the RAM.
    always_comb begin
        misaligned = 1'b0;
        case (bus.req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = bus.req_addr[0];
            SZ_WORD: misaligned = (bus.req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

`ifdef MEM_BIG_ENDIAN_EN
    assign byte_lane = 2'd3 - lat_addr[1:0];
    assign half_lane = ~lat_addr[1];
`else
    assign byte_lane = lat_addr[1:0];
    assign half_lane = lat_addr[1];
`endif

    // mem_rdata is the RAM's registered-address output, so it is valid in LDR/RMW
    // and the lane extraction/merge has to be combinational off it.
    always_comb begin
        byte_v = bus.mem_rdata[{byte_lane, 3'b000} +: 8];
        half_v = bus.mem_rdata[{half_lane, 4'b0000} +: 16];
        case (lat_size)
            SZ_BYTE: ld_val = {{24{lat_signed & byte_v[7]}}, byte_v};
            SZ_HALF: ld_val = {{16{lat_signed & half_v[15]}}, half_v};
            default: ld_val = bus.mem_rdata;
        endcase
    end

    always_comb begin
        merged = bus.mem_rdata;
        if (lat_size == SZ_BYTE)
            merged[{byte_lane, 3'b000} +: 8] = lat_wdata[7:0];
        else
            merged[{half_lane, 4'b0000} +: 16] = lat_wdata[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lat_write    <= 1'b0;
            lat_size     <= 2'b00;
            lat_signed   <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_write   <= bus.req_write;
                        lat_size    <= bus.req_size;
                        lat_signed  <= bus.req_signed;
                        lat_addr    <= bus.req_addr;
                        lat_wdata   <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        if (misaligned) begin
                            state        <= ERR;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (bus.req_write && bus.req_size == SZ_WORD) begin
                            state        <= WR;
                            mem_write_q  <= 1'b1;
                            mem_addr_q   <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                            resp_valid_q <= 1'b1;
                        end else begin
                            state      <= RD;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                        end
                    end
                end
                RD: begin
                    // mem_addr is left alone so the RAM read address stays put through RMW.
                    mem_read_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    if (lat_write) begin
                        state       <= RMW;
                        mem_write_q <= 1'b1;
                    end else begin
                        state <= LDR;
                    end
                end
                LDR, RMW, WR, ERR: begin
                    state        <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    mem_write_q  <= 1'b0;
                    mem_addr_q   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = (state == LDR) ? ld_val : '0;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = (state == RMW) ? merged :
                            (state == WR)  ? lat_wdata : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose : directed test of mem_access_unit against a small sync RAM model.
// Latency : checks per-request response latency (1 or 2 cycles after accept).
// Backpressure: requests are issued only while the unit is idle.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Word RAM: synchronous write, read address registered when mem_read is high.
    logic [31:0] ram [16];
    logic [3:0]  raddr = 4'd0;
    always @(posedge clk) begin
        if (bus.mem_write) ram[bus.mem_addr[5:2]] <= bus.mem_wdata;
        if (bus.mem_read)  raddr <= bus.mem_addr[5:2];
    end
    assign bus.mem_rdata = ram[raddr];

`ifdef MEM_BIG_ENDIAN_EN
    localparam logic [31:0] EXP_SB13   = 32'hDEADBEA5;
    localparam logic [31:0] EXP_SH12   = 32'hDEAD1234;
    localparam logic [31:0] EXP_LH10   = 32'hFFFFDEAD;
    localparam logic [31:0] EXP_LB10   = 32'hFFFFFFDE;
    localparam logic [31:0] EXP_LHU12  = 32'h0000BEEF;
`else
    localparam logic [31:0] EXP_SB13   = 32'hA5ADBEEF;
    localparam logic [31:0] EXP_SH12   = 32'h1234BEEF;
    localparam logic [31:0] EXP_LH10   = 32'hFFFFBEEF;
    localparam logic [31:0] EXP_LB10   = 32'hFFFFFFEF;
    localparam logic [31:0] EXP_LHU12  = 32'h0000DEAD;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request from idle and waits (bounded) for its response.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic touched, output logic [31:0] maddr);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        touched = 1'b0;
        while (!bus.resp_valid && lat < 8) begin
            touched = touched | bus.mem_read | bus.mem_write;
            @(posedge clk);
            #1;
            lat++;
        end
        touched = touched | bus.mem_read | bus.mem_write;
        if (!bus.resp_valid) chk("resp_timeout", 32'd0, 32'd1);
        rd    = bus.resp_rdata;
        er    = bus.resp_err;
        maddr = bus.mem_addr;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    logic [31:0] maddr;
    logic        er;
    logic        touched;
    int          lat;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        for (int i = 0; i < 16; i++) ram[i] = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_mem_rw",     {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        chk("rst_mem_addr",   bus.mem_addr, 32'd0);

        // SW then LW
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, touched, maddr);
        chk("sw_lat", lat, 1);
        chk("sw_err", {31'd0, er}, 32'd0);
        chk("sw_ram", ram[4], 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, touched, maddr);
        chk("lw_data", rd, 32'hDEADBEEF);
        chk("lw_lat", lat, 2);
        chk("lw_err", {31'd0, er}, 32'd0);
        chk("lw_addr", maddr, 32'h10);

        // SB then LB / LBU
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5, rd, er, lat, touched, maddr);
        chk("sb_lat", lat, 2);
        chk("sb_ram", ram[4], EXP_SB13);
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, lat, touched, maddr);
        chk("lb_data", rd, 32'hFFFFFFA5);
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er, lat, touched, maddr);
        chk("lbu_data", rd, 32'h000000A5);

        // SH then LH at both halves
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, rd, er, lat, touched, maddr);
        chk("sh_ram", ram[4], EXP_SH12);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, er, lat, touched, maddr);
        chk("lh12_data", rd, 32'h00001234);
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, rd, er, lat, touched, maddr);
        chk("lh10_data", rd, EXP_LH10);

        // Misaligned / illegal requests
        do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, rd, er, lat, touched, maddr);
        chk("lw11_err", {31'd0, er}, 32'd1);
        chk("lw11_lat", lat, 1);
        chk("lw11_data", rd, 32'd0);
        chk("lw11_noacc", {31'd0, touched}, 32'd0);
        do_req(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, rd, er, lat, touched, maddr);
        chk("lh13_err", {31'd0, er}, 32'd1);
        chk("lh13_noacc", {31'd0, touched}, 32'd0);
        do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, rd, er, lat, touched, maddr);
        chk("sz11_err", {31'd0, er}, 32'd1);
        chk("sz11_lat", lat, 1);
        chk("sz11_noacc", {31'd0, touched}, 32'd0);
        chk("sz11_ram", ram[4], EXP_SH12);

        // Reset asserted while an SB read-modify-write is about to commit
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, touched, maddr);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rmw_write_seen", {31'd0, bus.mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_req_ready",  {31'd0, bus.req_ready},  32'd1);
        chk("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("midrst_mem_rw",     {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        chk("midrst_mem_addr",   bus.mem_addr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ram", ram[4], 32'hDEADBEEF);

        // Lane mapping on an untouched word
        do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, rd, er, lat, touched, maddr);
        chk("lb10_data", rd, EXP_LB10);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, er, lat, touched, maddr);
        chk("lhu12_data", rd, EXP_LHU12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
